// File: rtl/ft601_pkg.sv
// Shared types for the FT601 245-mode FIFO bridge: the 36-bit bus word and the bus FSM states.
package ft601_pkg;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } ft_word_t;

    localparam int FT_WORD_W = $bits(ft_word_t);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_OE   = 3'd1,
        RD      = 3'd2,
        WR      = 3'd3,
        IDLE_TA = 3'd4
    } ft_state_e;

endpackage

// File: rtl/ft601_sync_fifo.sv
// First-word-fall-through synchronous FIFO with exact full/empty flags and an occupancy count.
// The head word is held in a register so downstream logic sees a flopped value.
module ft601_sync_fifo #(
    parameter int W  = 36,
    parameter int AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] head_q, head_d;
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = head_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // The next head comes from memory unless the word being written lands in
    // the slot that becomes the head (push into an empty or just-emptied FIFO).
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head_d   = mem_q[rd_ptr_d[AW-1:0]];
        if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
        head_q <= head_d;
    end

endmodule

// File: rtl/ft601_fifo_bridge.sv
// FPGA side of an FT601 in 245 synchronous-FIFO mode: TX FIFO bursts to the chip while txe_n is low,
// RX FIFO is filled from the chip while rxf_n is low and drained through a registered user read port.
module ft601_fifo_bridge
    import ft601_pkg::*;
#(
    parameter int TX_AW     = 10,
    parameter int RX_AW     = 10,
    parameter int RX_MARGIN = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    inout  wire  [31:0] ft601_data,
    inout  wire  [3:0]  ft601_be,
    input  logic        ft601_rxf_n,
    input  logic        ft601_txe_n,
    output logic        ft601_rd_n,
    output logic        ft601_wr_n,
    output logic        ft601_oe_n,
    output logic        ft601_siwu_n,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    input  logic        wr_valid,
    output logic        wr_fifo_full,
    output logic [31:0] rd_data,
    output logic [3:0]  rd_be,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic        rd_fifo_empty
);
    localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_LIMIT = (RX_AW+1)'(RX_MARGIN);
    localparam logic [TX_AW:0] TX_ONE   = {{TX_AW{1'b0}}, 1'b1};

    ft_state_e      state_q;
    logic           rd_n_q, wr_n_q, oe_n_q, drive_q;
    logic           rd_valid_q;
    ft_word_t       rd_word_q;

    ft_word_t       tx_wdata, tx_head, rx_wdata, rx_head;
    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic [TX_AW:0] tx_count;
    logic [RX_AW:0] rx_count, rx_free, rx_free_after;
    logic           tx_pop, tx_last, rx_push, rx_pop, rx_room, rd_stop;

    assign tx_wdata = {wr_be, wr_data};
    assign rx_wdata = {ft601_be, ft601_data};

    // A word leaves the TX FIFO only on an edge where the chip saw our strobe and was ready.
    assign tx_pop  = !wr_n_q && !ft601_txe_n;
    assign tx_last = tx_pop && (tx_count == TX_ONE) && !wr_valid;
    assign rx_push = !rd_n_q && !oe_n_q && !ft601_rxf_n;
    assign rx_pop  = rd_en && !rx_empty;

    assign rx_free       = RX_DEPTH - rx_count;
    assign rx_free_after = rx_free - {{RX_AW{1'b0}}, rx_push};
    assign rx_room       = rx_free > RX_LIMIT;
    assign rd_stop       = ft601_rxf_n || rx_full || (rx_free_after <= RX_LIMIT);

    ft601_sync_fifo #(.W(FT_WORD_W), .AW(TX_AW)) u_tx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (wr_valid),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    ft601_sync_fifo #(.W(FT_WORD_W), .AW(RX_AW)) u_rx_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (rx_push),
        .wdata_i (rx_wdata),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            drive_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!ft601_rxf_n && rx_room) begin
                        state_q <= RD_OE;
                        oe_n_q  <= 1'b0;
                    end else if (!ft601_txe_n && !tx_empty) begin
                        state_q <= WR;
                        wr_n_q  <= 1'b0;
                        drive_q <= 1'b1;
                    end
                end
                RD_OE: begin
                    state_q <= RD;
                    rd_n_q  <= 1'b0;
                end
                RD: begin
                    if (rd_stop) begin
                        state_q <= IDLE_TA;
                        rd_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                    end
                end
                WR: begin
                    if (ft601_txe_n || tx_last) begin
                        state_q <= IDLE_TA;
                        wr_n_q  <= 1'b1;
                        drive_q <= 1'b0;
                    end
                end
                IDLE_TA: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_word_q  <= '0;
        end else begin
            rd_valid_q <= rx_pop;
            if (rx_pop) begin
                rd_word_q <= rx_head;
            end
        end
    end

    assign ft601_data    = drive_q ? tx_head.data : 32'hz;
    assign ft601_be      = drive_q ? tx_head.be : 4'hz;
    assign ft601_rd_n    = rd_n_q;
    assign ft601_wr_n    = wr_n_q;
    assign ft601_oe_n    = oe_n_q;
    assign ft601_siwu_n  = 1'b1;

    assign wr_fifo_full  = tx_full;
    assign rd_fifo_empty = rx_empty;
    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_word_q.data;
    assign rd_be         = rd_word_q.be;

endmodule

// File: tb/tb_ft601_fifo_bridge.sv
// Directed bench for ft601_fifo_bridge with an FT601 bus model and TX/RX scoreboards.
`timescale 1ns/1ps
module tb_ft601_fifo_bridge;
    import ft601_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    wire  [31:0] ft_data;
    wire  [3:0]  ft_be;
    wire         ft_rxf_n;
    logic        txe_n = 1'b1;
    wire         ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        wr_valid = 1'b0;
    wire         wr_fifo_full;
    wire  [31:0] rd_data;
    wire  [3:0]  rd_be;
    logic        rd_en = 1'b0;
    wire         rd_valid, rd_fifo_empty;

    int checks = 0;
    int failures = 0;

    ft_word_t tx_exp[$];
    ft_word_t rx_exp[$];
    int       tx_seen = 0;
    int       rd_seen = 0;

    logic     rx_en = 1'b0;
    logic     rx_mode = 1'b0;
    int       rx_idx = 0;
    int       rx_total = 0;
    ft_word_t rx_cur;

    ft601_fifo_bridge dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ft601_data    (ft_data),
        .ft601_be      (ft_be),
        .ft601_rxf_n   (ft_rxf_n),
        .ft601_txe_n   (txe_n),
        .ft601_rd_n    (ft_rd_n),
        .ft601_wr_n    (ft_wr_n),
        .ft601_oe_n    (ft_oe_n),
        .ft601_siwu_n  (ft_siwu_n),
        .wr_data       (wr_data),
        .wr_be         (wr_be),
        .wr_valid      (wr_valid),
        .wr_fifo_full  (wr_fifo_full),
        .rd_data       (rd_data),
        .rd_be         (rd_be),
        .rd_en         (rd_en),
        .rd_valid      (rd_valid),
        .rd_fifo_empty (rd_fifo_empty)
    );

    always #5 clk = ~clk;

    function automatic ft_word_t tx_word(input int i);
        ft_word_t w;
        w.data = 32'(i);
        w.be   = 4'b0001 << ((i - 1) % 4);
        return w;
    endfunction

    function automatic ft_word_t model_word(input logic mode, input int idx);
        ft_word_t w;
        w.data = (mode ? 32'hB000_0000 : 32'hA000_0000) + 32'(idx);
        w.be   = mode ? ~4'(idx) : 4'(idx);
        return w;
    endfunction

    // FT601 side: drives RX data while oe_n is low, reports data available while words remain.
    assign rx_cur   = model_word(rx_mode, rx_idx);
    assign ft_data  = ft_oe_n ? 32'hz : rx_cur.data;
    assign ft_be    = ft_oe_n ? 4'hz : rx_cur.be;
    assign ft_rxf_n = !(rx_en && (rx_idx < rx_total));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // TX capture just before the edge on which the chip takes the word.
    always @(negedge clk) begin
        ft_word_t exp_w;
        #4;
        if (!ft_wr_n && !txe_n) begin
            tx_seen++;
            exp_w = (tx_exp.size() != 0) ? tx_exp.pop_front() : '1;
            check("tx_word", {ft_be, ft_data}, exp_w);
        end
    end

    // RX model: the word on the bus is taken at the coming edge, then the model advances.
    always @(negedge clk) begin
        logic adv;
        #4;
        adv = !ft_rd_n && !ft_oe_n && !ft_rxf_n;
        if (adv) rx_exp.push_back(model_word(rx_mode, rx_idx));
        #2;
        if (adv) rx_idx++;
    end

    always @(negedge clk) begin
        ft_word_t exp_w;
        #1;
        if (rd_valid) begin
            rd_seen++;
            exp_w = (rx_exp.size() != 0) ? rx_exp.pop_front() : '1;
            check("rd_word", {rd_be, rd_data}, exp_w);
        end
    end

    initial begin
        int       i;
        int       guard;
        logic     stalled;
        ft_word_t w;
        stalled = 1'b0;

        // Reset state
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_n", ft_rd_n, 1);
        check("rst_wr_n", ft_wr_n, 1);
        check("rst_oe_n", ft_oe_n, 1);
        check("rst_siwu_n", ft_siwu_n, 1);
        check("rst_bus_drive", dut.drive_q, 0);
        check("rst_full", wr_fifo_full, 0);
        check("rst_empty", rd_fifo_empty, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_word", {rd_be, rd_data}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // TX fill with chip not ready, full flag at 1024 pending, overflow word dropped
        for (i = 1; i <= 1024; i++) begin
            w = tx_word(i);
            {wr_be, wr_data} = w;
            wr_valid = 1'b1;
            tx_exp.push_back(w);
            @(negedge clk);
            if (i == 1023) check("full_at_1023", wr_fifo_full, 0);
        end
        check("full_at_1024", wr_fifo_full, 1);
        wr_data = 32'hDEAD_BEEF;
        wr_be   = 4'hF;
        @(negedge clk);
        wr_valid = 1'b0;
        check("full_after_drop", wr_fifo_full, 1);
        check("wr_n_while_txe_hi", ft_wr_n, 1);

        // TX stream with flow control, one 3-cycle txe_n stall mid-burst
        txe_n = 1'b0;
        i = 1025;
        guard = 0;
        while (i <= 4096 && guard < 20000) begin
            if (i == 2500 && !stalled) begin
                wr_valid = 1'b0;
                txe_n = 1'b1;
                @(negedge clk);
                check("stall_wr_n_rises", ft_wr_n, 1);
                repeat (2) @(negedge clk);
                txe_n = 1'b0;
                stalled = 1'b1;
                @(negedge clk);
                check("stall_wr_n_resumes", ft_wr_n, 0);
            end
            if (!wr_fifo_full) begin
                w = tx_word(i);
                {wr_be, wr_data} = w;
                wr_valid = 1'b1;
                tx_exp.push_back(w);
                i++;
            end else begin
                wr_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        wr_valid = 1'b0;
        guard = 0;
        while (tx_seen < 4096 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("tx_words_seen", tx_seen, 4096);
        check("tx_queue_drained", tx_exp.size(), 0);
        repeat (3) @(negedge clk);
        check("tx_idle_wr_n", ft_wr_n, 1);
        check("tx_idle_drive", dut.drive_q, 0);
        txe_n = 1'b1;

        // RX of ten words: oe_n leads rd_n by one cycle
        rx_mode = 1'b0;
        rx_idx = 0;
        rx_total = 10;
        rx_en = 1'b1;
        guard = 0;
        while (ft_oe_n && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rx_oe_n_low", ft_oe_n, 0);
        check("rx_rd_n_still_hi", ft_rd_n, 1);
        @(negedge clk);
        check("rx_rd_n_low", ft_rd_n, 0);
        guard = 0;
        while (rx_idx < 10 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rx_words_taken", rx_idx, 10);
        repeat (3) @(negedge clk);
        check("rx_done_rd_n", ft_rd_n, 1);
        check("rx_done_oe_n", ft_oe_n, 1);
        check("rx_fifo_not_empty", rd_fifo_empty, 0);
        check("rx_no_reads_yet", rd_seen, 0);
        rd_en = 1'b1;
        guard = 0;
        while (rd_seen < 10 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rd_en = 1'b0;
        check("rx_reads", rd_seen, 10);
        check("rx_queue_drained", rx_exp.size(), 0);
        check("rx_fifo_empty", rd_fifo_empty, 1);
        @(negedge clk);
        check("rx_rd_valid_low", rd_valid, 0);

        // RX backpressure: stop at 1020 stored words, then drain and resume
        rx_mode = 1'b1;
        rx_idx = 0;
        rx_total = 1100;
        guard = 0;
        while (rx_idx < 1020 && guard < 1300) begin
            @(negedge clk);
            guard++;
        end
        repeat (20) @(negedge clk);
        check("bp_words_taken", rx_idx, 1020);
        check("bp_rd_n_hi", ft_rd_n, 1);
        check("bp_oe_n_hi", ft_oe_n, 1);
        check("bp_rd_valid_low", rd_valid, 0);
        rd_en = 1'b1;
        guard = 0;
        while (rd_seen < 1110 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        rd_en = 1'b0;
        check("bp_reads", rd_seen, 1110);
        check("bp_model_done", rx_idx, 1100);
        check("bp_queue_drained", rx_exp.size(), 0);

        // Reset in the middle of a WR burst
        for (i = 0; i < 20; i++) begin
            w.data = 32'hC000_0000 + 32'(i);
            w.be = 4'hF;
            {wr_be, wr_data} = w;
            wr_valid = 1'b1;
            tx_exp.push_back(w);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        txe_n = 1'b0;
        guard = 0;
        while (tx_seen < 4101 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("mid_burst_seen", tx_seen, 4101);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_wr_n", ft_wr_n, 1);
        check("async_rst_drive", dut.drive_q, 0);
        check("async_rst_full", wr_fifo_full, 0);
        tx_exp.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (i = 0; i < 8; i++) begin
            w.data = 32'hE000_0000 + 32'(i);
            w.be = 4'(i);
            {wr_be, wr_data} = w;
            wr_valid = 1'b1;
            tx_exp.push_back(w);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        guard = 0;
        while (tx_seen < 4109 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        check("post_rst_seen", tx_seen, 4109);
        check("post_rst_queue", tx_exp.size(), 0);
        txe_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
